// File: rtl/prover_compute_v_ctrl_if.sv
// prover_compute_v_ctrl_if
//   Handshake and chain-control bundle for the compute-V chain sequencer.
//   master : drives start / n_elems / round_ack and observes status and controls
//   slave  : the sequencer itself
//   Signals:
//     start, n_elems   - sequence request and live element count at load
//     round_ack        - next-round challenge available
//     ready            - idle, start will be accepted
//     sr_en/sr_load/sr_bypass - broadcast controls to the shift-register chain
//     round_idx        - index of the round currently or last executed
//     round_done, done, err - one-cycle status pulses
interface prover_compute_v_ctrl_if #(
    parameter int NELEMS = 32,
    parameter int CNT_W  = $clog2(NELEMS + 1),
    parameter int RND_W  = $clog2(NELEMS) + 1
);
    logic             start;
    logic [CNT_W-1:0] n_elems;
    logic             round_ack;
    logic             ready;
    logic             sr_en;
    logic             sr_load;
    logic             sr_bypass;
    logic [RND_W-1:0] round_idx;
    logic             round_done;
    logic             done;
    logic             err;

    modport master (
        output start, n_elems, round_ack,
        input  ready, sr_en, sr_load, sr_bypass, round_idx, round_done, done, err
    );

    modport slave (
        input  start, n_elems, round_ack,
        output ready, sr_en, sr_load, sr_bypass, round_idx, round_done, done, err
    );
endinterface

// File: rtl/prover_compute_v_ctrl.sv
// prover_compute_v_ctrl
//   Sequencer for the compute-V shift-register chain. Parallel-loads the chain,
//   then runs folding rounds that each halve the live element count (an odd
//   leftover goes through the bypass path on the last shift cycle of a round).
//   Between rounds the chain is frozen until round_ack arrives.
//   Ports:
//     clk   - clock
//     rst   - synchronous reset, active-high
//     abort - (only with PROVER_COMPUTE_V_CTRL_ABORT_EN) drop the running sequence
//     bus   - prover_compute_v_ctrl_if.slave (start/n_elems/round_ack in,
//             ready/sr_*/round_idx/round_done/done/err out)
//   Optional feature macro: PROVER_COMPUTE_V_CTRL_ABORT_EN
//   All outputs are registered; they reflect the state entered at the last edge.
module prover_compute_v_ctrl #(
    parameter int NELEMS = 32,
    parameter int CNT_W  = $clog2(NELEMS + 1),
    parameter int RND_W  = $clog2(NELEMS) + 1
) (
    input  logic clk,
    input  logic rst,
`ifdef PROVER_COMPUTE_V_CTRL_ABORT_EN
    input  logic abort,
`endif
    prover_compute_v_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] live_reg;
    logic [CNT_W-1:0] out_cnt_reg;
    logic [CNT_W-1:0] cyc_reg;
    logic [RND_W-1:0] round_idx_reg;
    logic             ready_reg;
    logic             sr_en_reg;
    logic             sr_load_reg;
    logic             sr_bypass_reg;
    logic             round_done_reg;
    logic             done_reg;
    logic             err_reg;

    // ceil(v/2) with one extra bit so v+1 can never wrap.
    function automatic logic [CNT_W-1:0] half_up(input logic [CNT_W-1:0] v);
        logic [CNT_W:0] s;
        s = {1'b0, v} + {{CNT_W{1'b0}}, 1'b1};
        return s[CNT_W:1];
    endfunction

    logic [CNT_W-1:0] half_live;
    logic             start_ok;
    logic             last_cyc;
    logic             next_is_last;

    assign half_live    = half_up(live_reg);
    assign start_ok     = (bus.n_elems != '0) && (bus.n_elems <= CNT_W'(NELEMS));
    assign last_cyc     = (cyc_reg == (out_cnt_reg - CNT_W'(1)));
    // The cycle about to be entered is the last one of the round.
    assign next_is_last = ((cyc_reg + CNT_W'(1)) == (out_cnt_reg - CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            live_reg       <= '0;
            out_cnt_reg    <= '0;
            cyc_reg        <= '0;
            round_idx_reg  <= '0;
            ready_reg      <= 1'b1;
            sr_en_reg      <= 1'b0;
            sr_load_reg    <= 1'b0;
            sr_bypass_reg  <= 1'b0;
            round_done_reg <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            round_done_reg <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        if (start_ok) begin
                            live_reg      <= bus.n_elems;
                            round_idx_reg <= '0;
                            state_reg     <= LOAD;
                            ready_reg     <= 1'b0;
                            sr_en_reg     <= 1'b1;
                            sr_load_reg   <= 1'b1;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    sr_load_reg <= 1'b0;
                    if (live_reg == CNT_W'(1)) begin
                        state_reg <= DONE;
                        sr_en_reg <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        out_cnt_reg   <= half_live;
                        cyc_reg       <= '0;
                        state_reg     <= SHIFT;
                        sr_en_reg     <= 1'b1;
                        // Single-cycle round with an odd leftover bypasses at once.
                        sr_bypass_reg <= live_reg[0] && (half_live == CNT_W'(1));
                    end
                end

                SHIFT: begin
                    if (last_cyc) begin
                        live_reg       <= out_cnt_reg;
                        round_done_reg <= 1'b1;
                        sr_en_reg      <= 1'b0;
                        sr_bypass_reg  <= 1'b0;
                        if (out_cnt_reg > CNT_W'(1)) begin
                            state_reg <= WAIT;
                        end else begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end else begin
                        cyc_reg       <= cyc_reg + CNT_W'(1);
                        sr_bypass_reg <= live_reg[0] && next_is_last;
                    end
                end

                WAIT: begin
                    if (bus.round_ack) begin
                        round_idx_reg <= round_idx_reg + RND_W'(1);
                        out_cnt_reg   <= half_live;
                        cyc_reg       <= '0;
                        state_reg     <= SHIFT;
                        sr_en_reg     <= 1'b1;
                        sr_bypass_reg <= live_reg[0] && (half_live == CNT_W'(1));
                    end
                end

                DONE: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end

                default: begin
                    state_reg     <= IDLE;
                    ready_reg     <= 1'b1;
                    sr_en_reg     <= 1'b0;
                    sr_load_reg   <= 1'b0;
                    sr_bypass_reg <= 1'b0;
                end
            endcase

`ifdef PROVER_COMPUTE_V_CTRL_ABORT_EN
            // Placed after the case so it overrides whatever the state decided.
            if (abort && (state_reg == LOAD || state_reg == SHIFT || state_reg == WAIT)) begin
                state_reg      <= IDLE;
                ready_reg      <= 1'b1;
                sr_en_reg      <= 1'b0;
                sr_load_reg    <= 1'b0;
                sr_bypass_reg  <= 1'b0;
                round_idx_reg  <= '0;
                round_done_reg <= 1'b0;
                done_reg       <= 1'b0;
            end
`endif
        end
    end

    assign bus.ready      = ready_reg;
    assign bus.sr_en      = sr_en_reg;
    assign bus.sr_load    = sr_load_reg;
    assign bus.sr_bypass  = sr_bypass_reg;
    assign bus.round_idx  = round_idx_reg;
    assign bus.round_done = round_done_reg;
    assign bus.done       = done_reg;
    assign bus.err        = err_reg;

endmodule
